vga_squaredraw_axi_regs: RTL
============================

VGA_SQUAREDRAW_AXI_REGS -- requirements
Module: vga_squaredraw_axi_regs

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI data width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, byte address width (4 registers).
REQ-003 SHALL have port ACLK  in  1  single clock, all logic on rising edge.
REQ-004 SHALL have port ARESETN  in  1  reset, synchronous, active-low.
REQ-005 SHALL have ports S_AXI_AWADDR in 4, S_AXI_AWPROT in 3 (ignored), S_AXI_AWVALID in 1, S_AXI_AWREADY out 1  write address channel.
REQ-006 SHALL have ports S_AXI_WDATA in 32, S_AXI_WSTRB in 4, S_AXI_WVALID in 1, S_AXI_WREADY out 1  write data channel.
REQ-007 SHALL have ports S_AXI_BRESP out 2, S_AXI_BVALID out 1, S_AXI_BREADY in 1  write response channel.
REQ-008 SHALL have ports S_AXI_ARADDR in 4, S_AXI_ARPROT in 3 (ignored), S_AXI_ARVALID in 1, S_AXI_ARREADY out 1  read address channel.
REQ-009 SHALL have ports S_AXI_RDATA out 32, S_AXI_RRESP out 2, S_AXI_RVALID out 1, S_AXI_RREADY in 1  read data channel.
REQ-010 SHALL have port frame_start  in  1  one-cycle pulse at start of VGA frame (vblank).
REQ-011 SHALL have ports sq_xpos, sq_ypos, sq_size, sq_rgb  out  12 each, and sq_enable  out  1  active square parameters to the draw pipeline.

Function
REQ-012 Register map SHALL be: 0x0 XPOS, 0x4 YPOS, 0x8 SIZE, 0xC CTRL; all 32-bit fully stored, read/write; decode on ADDR[3:2], ADDR[1:0] ignored.
REQ-013 Field mapping SHALL be: sq_xpos=XPOS[11:0], sq_ypos=YPOS[11:0], sq_size=SIZE[11:0], sq_rgb=CTRL[11:0], sq_enable=CTRL[31].
REQ-014 Write path SHALL be an FSM: W_IDLE, W_ADDR (address held), W_DATA (data held), W_RESP; AW and W accepted independently in any order or same cycle.
REQ-015 AWREADY SHALL be 1 only in W_IDLE or W_DATA; WREADY only in W_IDLE or W_ADDR; both 0 in W_RESP.
REQ-016 On the edge completing the second of the two handshakes the register SHALL be written (only bytes with WSTRB[i]=1 updated), BVALID set to 1, state W_RESP.
REQ-017 BVALID SHALL hold with BRESP=OKAY(2'b00) until BREADY=1, then clear and return to W_IDLE; next write accepted the cycle after.
REQ-018 Read path: ARREADY SHALL be 1 when RVALID=0; on AR handshake, RDATA latches the addressed register and RVALID=1 at the next edge.
REQ-019 RDATA/RVALID SHALL remain stable until RREADY=1; RRESP always OKAY; no new AR accepted while RVALID=1.
REQ-020 A read in the same cycle as a write commit to the same register SHALL return the pre-write value.
REQ-021 Square outputs SHALL be shadow registers loaded from the register file only on cycles with frame_start=1; otherwise held (tear-free update).
REQ-022 If a write commits in the frame_start cycle, shadows SHALL capture the old value; the new value appears at the next frame_start.
REQ-023 Read and write paths SHALL operate concurrently without interference.

Reset
REQ-024 With ARESETN=0 at a rising edge: all four registers, all shadows, BVALID, RVALID, RDATA SHALL be 0; write FSM W_IDLE.
REQ-025 During reset AWREADY, WREADY, ARREADY SHALL be 0; they may assert from the first edge with ARESETN=1.
REQ-026 Reset mid-transaction SHALL abort it: held address/data discarded, no register update, no pending response.

Structure
REQ-027 Package vga_squaredraw_pkg SHALL hold register offsets, field widths (12), CTRL enable bit index (31), AXI resp codes and the write FSM state enum.
REQ-028 Single module; no sub-module required.

Verification
REQ-029 Write 0x1,0x2,0x3,0x4 to 0x0..0xC, read back -> 0x1,0x2,0x3,0x4, BRESP/RRESP=OKAY.
REQ-030 W before AW by 3 cycles (data 0x123 to 0x0) -> WREADY drops after W handshake, single B, XPOS=0x123.
REQ-031 XPOS=0xFFFFFFFF then write 0x00000055 with WSTRB=4'b0001 -> readback 0xFFFFFF55.
REQ-032 BREADY held 0 for 5 cycles -> BVALID stays 1, AWREADY/WREADY 0, no second write accepted; RREADY=0 similarly holds RDATA.
REQ-033 Write XPOS=0x0A0 and CTRL=0x80000F00; sq_xpos=0, sq_enable=0 until frame_start pulse -> next cycle sq_xpos=0x0A0, sq_rgb=0xF00, sq_enable=1; write coincident with frame_start -> old value captured.
REQ-034 ARESETN low for 1 cycle after AW handshake (before W) -> no register change, BVALID=0, all registers read 0.

Source files
------------

// File: rtl/vga_squaredraw_pkg.sv
// Shared constants for the square-draw AXI4-Lite register block: register map,
// field geometry, response codes and the write-channel state encoding.
package vga_squaredraw_pkg;

    localparam int REG_COUNT   = 4;
    localparam int FIELD_W     = 12;
    localparam int CTRL_EN_BIT = 31;

    // Byte offsets as seen on the bus; the word index is offset[3:2].
    localparam logic [3:0] OFF_XPOS = 4'h0;
    localparam logic [3:0] OFF_YPOS = 4'h4;
    localparam logic [3:0] OFF_SIZE = 4'h8;
    localparam logic [3:0] OFF_CTRL = 4'hC;

    localparam logic [1:0] IDX_XPOS = OFF_XPOS[3:2];
    localparam logic [1:0] IDX_YPOS = OFF_YPOS[3:2];
    localparam logic [1:0] IDX_SIZE = OFF_SIZE[3:2];
    localparam logic [1:0] IDX_CTRL = OFF_CTRL[3:2];

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_DATA = 2'd2,
        W_RESP = 2'd3
    } wr_state_t;

endpackage

// File: rtl/vga_squaredraw_axi_regs.sv
// AXI4-Lite slave holding the square position/size/colour registers, with
// frame-synchronous shadow copies driving the VGA draw pipeline.
module vga_squaredraw_axi_regs
    import vga_squaredraw_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,

    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,

    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,

    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,

    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,

    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,

    input  logic                              frame_start,
    output logic [FIELD_W-1:0]                sq_xpos,
    output logic [FIELD_W-1:0]                sq_ypos,
    output logic [FIELD_W-1:0]                sq_size,
    output logic [FIELD_W-1:0]                sq_rgb,
    output logic                              sq_enable
);

    localparam int DATA_W = C_S_AXI_DATA_WIDTH;
    localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

    function automatic logic [DATA_W-1:0] apply_wstrb(
        input logic [DATA_W-1:0] old_val,
        input logic [DATA_W-1:0] new_val,
        input logic [STRB_W-1:0] strb
    );
        logic [DATA_W-1:0] merged;
        merged = old_val;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) merged[8*b +: 8] = new_val[8*b +: 8];
        end
        return merged;
    endfunction

    logic [DATA_W-1:0] regs [REG_COUNT];

    wr_state_t         wr_state;
    logic              awready;
    logic              wready;
    logic              bvalid;
    logic [1:0]        awaddr_hold;
    logic [DATA_W-1:0] wdata_hold;
    logic [STRB_W-1:0] wstrb_hold;

    logic              arready;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    logic [FIELD_W-1:0] xpos_shadow;
    logic [FIELD_W-1:0] ypos_shadow;
    logic [FIELD_W-1:0] size_shadow;
    logic [FIELD_W-1:0] rgb_shadow;
    logic               enable_shadow;

    logic aw_hs;
    logic w_hs;
    logic ar_hs;

    logic              commit_en;
    logic [1:0]        commit_idx;
    logic [DATA_W-1:0] commit_data;
    logic [STRB_W-1:0] commit_strb;

    logic unused_bits;

    assign aw_hs = S_AXI_AWVALID && awready;
    assign w_hs  = S_AXI_WVALID  && wready;
    assign ar_hs = S_AXI_ARVALID && arready;

    // Protection bits and byte-lane address bits carry no meaning here.
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // The write lands on whichever edge completes the second handshake,
    // taking the other half from the hold registers when it arrived earlier.
    always_comb begin
        commit_en   = 1'b0;
        commit_idx  = S_AXI_AWADDR[3:2];
        commit_data = S_AXI_WDATA;
        commit_strb = S_AXI_WSTRB;
        case (wr_state)
            W_IDLE: commit_en = aw_hs && w_hs;
            W_ADDR: begin
                commit_en  = w_hs;
                commit_idx = awaddr_hold;
            end
            W_DATA: begin
                commit_en   = aw_hs;
                commit_data = wdata_hold;
                commit_strb = wstrb_hold;
            end
            default: commit_en = 1'b0;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (aw_hs) awaddr_hold <= S_AXI_AWADDR[3:2];
        if (w_hs) begin
            wdata_hold <= S_AXI_WDATA;
            wstrb_hold <= S_AXI_WSTRB;
        end
    end

    // Write FSM: ready flags are registered copies of the next state's
    // acceptance rules so they stay low through reset.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            wr_state <= W_IDLE;
            awready  <= 1'b0;
            wready   <= 1'b0;
            bvalid   <= 1'b0;
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
        end else begin
            if (commit_en) begin
                regs[commit_idx] <= apply_wstrb(regs[commit_idx], commit_data, commit_strb);
            end
            case (wr_state)
                W_IDLE: begin
                    awready <= 1'b1;
                    wready  <= 1'b1;
                    if (aw_hs && w_hs) begin
                        wr_state <= W_RESP;
                        awready  <= 1'b0;
                        wready   <= 1'b0;
                        bvalid   <= 1'b1;
                    end else if (aw_hs) begin
                        wr_state <= W_ADDR;
                        awready  <= 1'b0;
                    end else if (w_hs) begin
                        wr_state <= W_DATA;
                        wready   <= 1'b0;
                    end
                end
                W_ADDR: begin
                    if (w_hs) begin
                        wr_state <= W_RESP;
                        wready   <= 1'b0;
                        bvalid   <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (aw_hs) begin
                        wr_state <= W_RESP;
                        awready  <= 1'b0;
                        bvalid   <= 1'b1;
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        wr_state <= W_IDLE;
                        awready  <= 1'b1;
                        wready   <= 1'b1;
                        bvalid   <= 1'b0;
                    end
                end
                default: begin
                    wr_state <= W_IDLE;
                    awready  <= 1'b0;
                    wready   <= 1'b0;
                    bvalid   <= 1'b0;
                end
            endcase
        end
    end

    // Read path samples the register file before any same-edge write lands.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
        end else if (ar_hs) begin
            arready <= 1'b0;
            rvalid  <= 1'b1;
            rdata   <= regs[S_AXI_ARADDR[3:2]];
        end else if (rvalid) begin
            if (S_AXI_RREADY) begin
                rvalid  <= 1'b0;
                arready <= 1'b1;
            end
        end else begin
            arready <= 1'b1;
        end
    end

    // Shadows refresh only at frame start so a frame never draws half-updated.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            xpos_shadow   <= '0;
            ypos_shadow   <= '0;
            size_shadow   <= '0;
            rgb_shadow    <= '0;
            enable_shadow <= 1'b0;
        end else if (frame_start) begin
            xpos_shadow   <= regs[IDX_XPOS][FIELD_W-1:0];
            ypos_shadow   <= regs[IDX_YPOS][FIELD_W-1:0];
            size_shadow   <= regs[IDX_SIZE][FIELD_W-1:0];
            rgb_shadow    <= regs[IDX_CTRL][FIELD_W-1:0];
            enable_shadow <= regs[IDX_CTRL][CTRL_EN_BIT];
        end
    end

    assign S_AXI_AWREADY = awready;
    assign S_AXI_WREADY  = wready;
    assign S_AXI_BVALID  = bvalid;
    assign S_AXI_BRESP   = RESP_OKAY;
    assign S_AXI_ARREADY = arready;
    assign S_AXI_RVALID  = rvalid;
    assign S_AXI_RDATA   = rdata;
    assign S_AXI_RRESP   = RESP_OKAY;

    assign sq_xpos   = xpos_shadow;
    assign sq_ypos   = ypos_shadow;
    assign sq_size   = size_shadow;
    assign sq_rgb    = rgb_shadow;
    assign sq_enable = enable_shadow;

endmodule
